// File: rtl/alu_reservation_station_if.sv
// Shared types for the ALU reservation station and the interface bundling its
// dispatch, CDB snoop and issue connections.
package alu_rs_pkg;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;

    typedef enum logic [1:0] {
        op_b_imm   = 2'd0,
        op_b_reg   = 2'd1,
        op_b_lui   = 2'd2,
        op_b_auipc = 2'd3
    } alu_op_t;

    typedef struct packed {
        alu_op_t             opcode;
        logic [PREG_W-1:0]   ps1_addr;
        logic [PREG_W-1:0]   ps2_addr;
        logic [PREG_W-1:0]   pd_addr;
        logic [ROB_W-1:0]    rob_id;
        logic [31:0]         imm;
    } rs_entry_t;

    typedef struct packed {
        logic                ready;
        logic [PREG_W-1:0]   pr_dest;
    } cdb_t;
endpackage

interface alu_rs_if #(
    parameter int DEPTH     = 8,
    parameter int CDB_PORTS = 2
);
    import alu_rs_pkg::*;

    logic                     dispatch_valid;
    rs_entry_t                dispatch_entry;
    logic                     dispatch_ps1_ready;
    logic                     dispatch_ps2_ready;
    logic                     dispatch_ready;
    cdb_t [CDB_PORTS-1:0]     cdb;
    logic                     issue_valid;
    rs_entry_t                issue_entry;
    logic                     issue_ready;
    logic [PREG_W-1:0]        ps1_addr;
    logic [PREG_W-1:0]        ps2_addr;
    logic [$clog2(DEPTH):0]   occupancy;

    // Reservation-station side.
    modport slave (
        input  dispatch_valid, dispatch_entry, dispatch_ps1_ready, dispatch_ps2_ready,
        input  cdb, issue_ready,
        output dispatch_ready, issue_valid, issue_entry, ps1_addr, ps2_addr, occupancy
    );

    // Dispatch / CDB / ALU side.
    modport master (
        output dispatch_valid, dispatch_entry, dispatch_ps1_ready, dispatch_ps2_ready,
        output cdb, issue_ready,
        input  dispatch_ready, issue_valid, issue_entry, ps1_addr, ps2_addr, occupancy
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Reservation station for ALU micro-ops: holds dispatched entries, wakes operands
// from the CDB and issues the lowest-index eligible entry each cycle.
module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CDB_PORTS = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    alu_rs_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_rdy1;
    logic [DEPTH-1:0] r_rdy2;
    rs_entry_t        r_entry [DEPTH];
    logic [OCC_W-1:0] r_occ;

    logic [DEPTH-1:0] w_wake1;
    logic [DEPTH-1:0] w_wake2;
    logic [DEPTH-1:0] w_elig;
    logic [IDX_W-1:0] w_sel;
    logic             w_any_elig;
    logic [IDX_W-1:0] w_free;
    logic             w_disp_wake1;
    logic             w_disp_wake2;
    logic             w_disp_fire;
    logic             w_issue_fire;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_m1;
            logic w_m2;
            logic w_no_operands;

            always_comb begin
                w_m1 = 1'b0;
                w_m2 = 1'b0;
                for (int p = 0; p < CDB_PORTS; p++) begin
                    if (bus.cdb[p].ready && bus.cdb[p].pr_dest == r_entry[gi].ps1_addr) w_m1 = 1'b1;
                    if (bus.cdb[p].ready && bus.cdb[p].pr_dest == r_entry[gi].ps2_addr) w_m2 = 1'b1;
                end
            end

            assign w_no_operands = (r_entry[gi].opcode == op_b_lui) || (r_entry[gi].opcode == op_b_auipc);
            assign w_wake1[gi]   = w_m1;
            assign w_wake2[gi]   = w_m2;
            // Eligibility looks only at registered ready bits, so a wakeup takes effect next cycle.
            assign w_elig[gi]    = r_valid[gi] &
                                   (w_no_operands |
                                    (r_rdy1[gi] & ((r_entry[gi].opcode == op_b_imm) | r_rdy2[gi])));
        end
    endgenerate

    always_comb begin
        w_disp_wake1 = 1'b0;
        w_disp_wake2 = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (bus.cdb[p].ready && bus.cdb[p].pr_dest == bus.dispatch_entry.ps1_addr) w_disp_wake1 = 1'b1;
            if (bus.cdb[p].ready && bus.cdb[p].pr_dest == bus.dispatch_entry.ps2_addr) w_disp_wake2 = 1'b1;
        end
    end

    // Lowest-index eligible entry and lowest-index free entry.
    always_comb begin
        w_sel      = '0;
        w_any_elig = 1'b0;
        w_free     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel      = IDX_W'(i);
                w_any_elig = 1'b1;
            end
            if (!r_valid[i]) w_free = IDX_W'(i);
        end
    end

    assign bus.dispatch_ready = (r_occ < OCC_W'(DEPTH));
    assign w_disp_fire        = bus.dispatch_valid & bus.dispatch_ready & ~flush;
    assign bus.issue_valid    = w_any_elig & ~flush;
    assign w_issue_fire       = bus.issue_valid & bus.issue_ready;
    assign bus.issue_entry    = r_entry[w_sel];
    assign bus.ps1_addr       = bus.issue_entry.ps1_addr;
    assign bus.ps2_addr       = bus.issue_entry.ps2_addr;
    assign bus.occupancy      = r_occ;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue_fire && w_sel == IDX_W'(i)) r_valid[i] <= 1'b0;
                if (w_disp_fire && w_free == IDX_W'(i)) r_valid[i] <= 1'b1;
            end
            r_occ <= r_occ + OCC_W'(w_disp_fire) - OCC_W'(w_issue_fire);
        end
    end

    // Payload and ready bits carry no reset; they are only meaningful under r_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_disp_fire && w_free == IDX_W'(i)) begin
                r_entry[i] <= bus.dispatch_entry;
                r_rdy1[i]  <= bus.dispatch_ps1_ready | w_disp_wake1;
                r_rdy2[i]  <= bus.dispatch_ps2_ready | w_disp_wake2;
            end else begin
                r_rdy1[i]  <= r_rdy1[i] | w_wake1[i];
                r_rdy2[i]  <= r_rdy2[i] | w_wake2[i];
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: dispatch, wakeup, select order,
// stall hold and flush, each checked against hand-computed values.
module tb_alu_reservation_station;
    import alu_rs_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   n_checks;
    int   n_errors;

    alu_rs_if #(.DEPTH(8), .CDB_PORTS(2)) bus ();

    alu_reservation_station #(.DEPTH(8), .CDB_PORTS(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dispatch(input alu_op_t op, input int ps1, input int ps2, input int rob,
                                  input logic r1, input logic r2);
        bus.dispatch_valid          = 1'b1;
        bus.dispatch_entry.opcode   = op;
        bus.dispatch_entry.ps1_addr = PREG_W'(ps1);
        bus.dispatch_entry.ps2_addr = PREG_W'(ps2);
        bus.dispatch_entry.pd_addr  = PREG_W'(rob);
        bus.dispatch_entry.rob_id   = ROB_W'(rob);
        bus.dispatch_entry.imm      = 32'(rob);
        bus.dispatch_ps1_ready      = r1;
        bus.dispatch_ps2_ready      = r2;
    endtask

    task automatic no_dispatch();
        bus.dispatch_valid     = 1'b0;
        bus.dispatch_ps1_ready = 1'b0;
        bus.dispatch_ps2_ready = 1'b0;
    endtask

    task automatic set_cdb(input logic v0, input int t0, input logic v1, input int t1);
        bus.cdb[0].ready   = v0;
        bus.cdb[0].pr_dest = PREG_W'(t0);
        bus.cdb[1].ready   = v1;
        bus.cdb[1].pr_dest = PREG_W'(t1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        flush = 1'b0;
        bus.dispatch_entry = '0;
        no_dispatch();
        set_cdb(0, 0, 0, 0);
        bus.issue_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_issue_valid", 32'(bus.issue_valid), 0);
        check("rst_dispatch_ready", 32'(bus.dispatch_ready), 1);
        check("rst_occupancy", 32'(bus.occupancy), 0);

        // Both sources ready: issues the cycle after dispatch.
        drive_dispatch(op_b_reg, 5, 6, 1, 1, 1);
        #1;
        check("t1_same_cycle_valid", 32'(bus.issue_valid), 0);
        step();
        no_dispatch();
        #1;
        check("t1_issue_valid", 32'(bus.issue_valid), 1);
        check("t1_ps1_addr", 32'(bus.ps1_addr), 5);
        check("t1_ps2_addr", 32'(bus.ps2_addr), 6);
        check("t1_rob", 32'(bus.issue_entry.rob_id), 1);
        check("t1_occ_one", 32'(bus.occupancy), 1);
        step();
        check("t1_occ_zero", 32'(bus.occupancy), 0);
        check("t1_empty_valid", 32'(bus.issue_valid), 0);

        // Source 1 unready until a CDB broadcast on port 1.
        drive_dispatch(op_b_reg, 7, 8, 2, 0, 1);
        #1;
        step();
        no_dispatch();
        #1;
        check("t2_wait_a", 32'(bus.issue_valid), 0);
        step();
        check("t2_wait_b", 32'(bus.issue_valid), 0);
        set_cdb(0, 0, 1, 7);
        #1;
        check("t2_cdb_cycle", 32'(bus.issue_valid), 0);
        step();
        set_cdb(0, 0, 0, 0);
        #1;
        check("t2_woken_valid", 32'(bus.issue_valid), 1);
        check("t2_woken_rob", 32'(bus.issue_entry.rob_id), 2);
        step();
        check("t2_occ", 32'(bus.occupancy), 0);

        // CDB hit in the dispatch cycle itself.
        drive_dispatch(op_b_reg, 10, 9, 3, 1, 0);
        set_cdb(1, 9, 0, 0);
        #1;
        step();
        no_dispatch();
        set_cdb(0, 0, 0, 0);
        #1;
        check("t3_valid", 32'(bus.issue_valid), 1);
        check("t3_rob", 32'(bus.issue_entry.rob_id), 3);
        check("t3_ps2", 32'(bus.ps2_addr), 9);
        step();
        check("t3_occ", 32'(bus.occupancy), 0);

        // Fill all entries with unready sources (ps1=20+i, ps2=40+i, rob=8+i).
        for (int i = 0; i < 8; i++) begin
            drive_dispatch(op_b_reg, 20 + i, 40 + i, 8 + i, 0, 0);
            #1;
            step();
        end
        no_dispatch();
        #1;
        check("t4_full_dready", 32'(bus.dispatch_ready), 0);
        check("t4_full_occ", 32'(bus.occupancy), 8);
        check("t4_full_valid", 32'(bus.issue_valid), 0);
        set_cdb(1, 23, 1, 25);
        #1;
        step();
        set_cdb(1, 43, 1, 45);
        #1;
        check("t4_half_woken", 32'(bus.issue_valid), 0);
        step();
        set_cdb(0, 0, 0, 0);
        drive_dispatch(op_b_lui, 0, 0, 60, 0, 0);
        #1;
        check("t4_e3_valid", 32'(bus.issue_valid), 1);
        check("t4_e3_rob", 32'(bus.issue_entry.rob_id), 11);
        check("t4_full_issue_dready", 32'(bus.dispatch_ready), 0);
        step();
        no_dispatch();
        #1;
        check("t4_occ_after_e3", 32'(bus.occupancy), 7);
        check("t4_dready_back", 32'(bus.dispatch_ready), 1);
        check("t4_e5_rob", 32'(bus.issue_entry.rob_id), 13);
        step();
        check("t4_occ_after_e5", 32'(bus.occupancy), 6);
        check("t4_none_elig", 32'(bus.issue_valid), 0);

        // ALU stalled: lui held and reselected each cycle.
        bus.issue_ready = 1'b0;
        drive_dispatch(op_b_lui, 30, 31, 30, 0, 0);
        #1;
        check("t5_dispatch_cycle", 32'(bus.issue_valid), 0);
        step();
        no_dispatch();
        #1;
        check("t5_occ", 32'(bus.occupancy), 7);
        for (int k = 0; k < 3; k++) begin
            check("t5_hold_valid", 32'(bus.issue_valid), 1);
            check("t5_hold_rob", 32'(bus.issue_entry.rob_id), 30);
            step();
        end
        bus.issue_ready = 1'b1;
        #1;
        check("t5_release_rob", 32'(bus.issue_entry.rob_id), 30);
        step();
        check("t5_freed_occ", 32'(bus.occupancy), 6);
        check("t5_freed_valid", 32'(bus.issue_valid), 0);

        // imm only needs source 1.
        drive_dispatch(op_b_imm, 11, 12, 31, 1, 0);
        #1;
        step();
        no_dispatch();
        #1;
        check("t6_imm_valid", 32'(bus.issue_valid), 1);
        check("t6_imm_rob", 32'(bus.issue_entry.rob_id), 31);
        step();
        check("t6_occ", 32'(bus.occupancy), 6);

        // Drain entries 0 and 1 to reach occupancy 4.
        set_cdb(1, 20, 1, 21);
        #1;
        step();
        set_cdb(1, 40, 1, 41);
        #1;
        step();
        set_cdb(0, 0, 0, 0);
        #1;
        check("t7_e0_rob", 32'(bus.issue_entry.rob_id), 8);
        step();
        check("t7_e1_rob", 32'(bus.issue_entry.rob_id), 9);
        step();
        check("t7_occ4", 32'(bus.occupancy), 4);
        set_cdb(1, 22, 1, 42);
        #1;
        step();
        set_cdb(0, 0, 0, 0);
        #1;
        check("t7_e2_elig", 32'(bus.issue_valid), 1);
        flush = 1'b1;
        drive_dispatch(op_b_reg, 13, 14, 50, 1, 1);
        #1;
        check("t7_flush_valid", 32'(bus.issue_valid), 0);
        check("t7_flush_dready", 32'(bus.dispatch_ready), 1);
        step();
        flush = 1'b0;
        no_dispatch();
        #1;
        check("t7_post_occ", 32'(bus.occupancy), 0);
        check("t7_post_valid", 32'(bus.issue_valid), 0);
        step();
        check("t7_no_alloc_valid", 32'(bus.issue_valid), 0);
        check("t7_no_alloc_occ", 32'(bus.occupancy), 0);

        // Normal operation after flush.
        drive_dispatch(op_b_reg, 15, 16, 51, 1, 1);
        #1;
        step();
        no_dispatch();
        #1;
        check("t8_valid", 32'(bus.issue_valid), 1);
        check("t8_rob", 32'(bus.issue_entry.rob_id), 51);
        check("t8_occ", 32'(bus.occupancy), 1);
        step();
        check("t8_occ_zero", 32'(bus.occupancy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

- Holds renamed ALU-class micro-ops (op_b_imm, op_b_reg, op_b_lui, op_b_auipc) between dispatch and the base ALU functional unit.
- Snoops every common data bus (CDB) port to wake up operands.
- Issues one ready entry per cycle to the ALU over the rs_entry_valid/ready handshake and drives the physical regfile read addresses for that entry.
- Sits between rename/dispatch and the ALU; it is the initiator for the ALU's issue port.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two, ≥2)
- CDB_PORTS, 2, number of CDB broadcast ports snooped

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  branch-mispredict flush; kills all entries
- dispatch_valid  in  1  dispatch presents an entry
- dispatch_entry  in  rs_entry_t  entry (uses ps1_addr, ps2_addr, pd_addr, rob_id, opcode)
- dispatch_ps1_ready  in  1  source 1 value already in regfile
- dispatch_ps2_ready  in  1  source 2 value already in regfile
- dispatch_ready  out  1  a free entry exists; dispatch fires on valid&ready
- cdb  in  cdb_t[CDB_PORTS]  broadcasts; a port is live when .ready=1, tag is .pr_dest
- issue_valid  out  1  to ALU rs_entry_valid
- issue_entry  out  rs_entry_t  to ALU rs_entry_dout
- issue_ready  in  1  from ALU ready (low = ALU stalled)
- ps1_addr  out  $bits(pd_addr)  regfile read address 1 = issue_entry.ps1_addr
- ps2_addr  out  $bits(pd_addr)  regfile read address 2 = issue_entry.ps2_addr
- occupancy  out  $clog2(DEPTH)+1  valid entry count

## Operation
- Per entry: valid, rs_entry_t, rdy1, rdy2. All held in flops.
- Allocation: on dispatch fire, write the lowest-index entry invalid at cycle start; set valid=1.
- Dispatch ready bits captured: rdy1 = dispatch_ps1_ready OR any live CDB port whose pr_dest == ps1_addr in the same cycle; likewise rdy2.
- Wakeup: each cycle, for every valid entry and every live CDB port, pr_dest == ps1_addr sets rdy1 and pr_dest == ps2_addr sets rdy2. Bits never clear except on free/flush.
- op_b_lui and op_b_auipc ignore operands: they are eligible regardless of rdy1/rdy2. op_b_imm ignores rdy2.
- Select: among eligible entries (valid and required rdy bits set, from registered state), pick the lowest index. issue_valid = any eligible. issue_entry, ps1_addr, ps2_addr come from the selected entry. Select is combinational from flops.
- Issue fires on issue_valid & issue_ready; the selected entry's valid clears at that edge.
- When issue_ready=0, issue_valid may stay high. The entry is held and reselected next cycle. Selection may change if a lower-index entry becomes eligible.
- Flush: at the edge, clear every valid bit. During the flush cycle, force issue_valid=0 and ignore dispatch (no allocation). dispatch_ready is still computed normally.
- Reset: same effect as flush. Payload flops are not reset.
- occupancy: registered count of valid entries. Updates +1 on dispatch fire, −1 on issue fire, net 0 when both fire, 0 on flush/rst.

## Timing
- Reset values: issue_valid=0, dispatch_ready=1, occupancy=0. ps1_addr, ps2_addr and issue_entry are don't-care while issue_valid=0.
- dispatch_ready = occupancy < DEPTH, from registered state. An entry freed by issue this cycle is not reusable until next cycle, so full + simultaneous issue still deasserts dispatch_ready.
- Dispatch-to-issue latency: an entry dispatched in cycle N with both sources ready can issue no earlier than N+1.
- Wakeup-to-issue latency: CDB broadcast in cycle N → eligible in N+1. The regfile writes CDB results at the end of N, so the read in N+1 returns the new value.
- Multiple CDB ports matching the same tag in one cycle are legal, with the same effect as one.
- Flush and dispatch_valid in the same cycle: no entry is allocated. Flush has priority over issue and wakeup.
- Empty: issue_valid=0. Full: dispatch_ready=0 and all entries retained.

## Test plan
- Reset, then dispatch op_b_reg with ps1_addr=5 and ps2_addr=6, both ready flags set, issue_ready=1 → issue_valid=1 next cycle with ps1_addr=5, ps2_addr=6; occupancy goes 1→0.
- Dispatch op_b_reg with ps1_addr=7 not ready → no issue. Then cdb[1].ready=1, pr_dest=7 in cycle N → issue_valid=1 in N+1, not in N.
- Same cycle: dispatch with ps2_addr=9 not ready and CDB pr_dest=9 live → entry issues the next cycle.
- Fill all 8 entries with unready sources → dispatch_ready=0, occupancy=8. Wake entries 3 and 5 together → entry 3 issues first, entry 5 the following cycle. dispatch_ready returns to 1 in the cycle after entry 3 issues.
- Hold issue_ready=0 for 3 cycles with one eligible op_b_lui → issue_valid stays 1 with the same rob_id each cycle. Raise issue_ready → entry freed at that edge.
- With occupancy=4, assert flush together with dispatch_valid=1 → next cycle occupancy=0, issue_valid=0, and no allocation occurred.
